fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_instr_queue.sv | 77 +++++++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage, its instruction queue and the decoder.
package fetch_pkg;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
        return a & ~(INSTR_W'(3));
    endfunction
endpackage

// File: rtl/fetch_if.sv
// Imem request, branch redirect and decode-facing valid/ready signals around the fetch stage.
// master = fetch stage side, slave = memory/execute/decode environment side.
interface fetch_if;
    import fetch_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    logic               redirect_valid;
    logic [INSTR_W-1:0] redirect_target;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rdata, redirect_valid, redirect_target, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rdata, redirect_valid, redirect_target, instr_ready
    );
endinterface

// File: rtl/fetch_instr_queue.sv
// In-order buffer of {instr, pc}; a pushed entry is readable the cycle after the push.
// Flush empties it at the edge and overrides push/pop; push into a full queue only lands with a pop.
module instr_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  fetch_entry_t                 push_dat_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output fetch_entry_t                 head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so an empty queue presents a zero instruction/pc.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Program counter, imem request FSM and redirect handling; accepted words reach decode one cycle later.
// Stops requesting when the 2-entry queue is full; imem_req/imem_addr come from registered state only.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] drain_addr_q, drain_addr_d;

    logic               req;
    logic [INSTR_W-1:0] req_addr;
    logic               push, pop;
    logic               q_full, q_empty;
    logic [CNT_W-1:0]   q_count;
    fetch_entry_t       q_head, q_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect is decided against the request already on the bus: an unfinished one must be drained.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = (req && !bus.imem_ready) ? DRAIN : FETCH;
        end else begin
            unique case (state_q)
                FETCH:   if (push && !pop && q_count == CNT_W'(DEPTH - 1)) state_d = HOLD;
                HOLD:    if (pop) state_d = FETCH;
                DRAIN:   if (bus.imem_ready) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        req      = 1'b0;
        req_addr = pc_q;
        unique case (state_q)
            FETCH: req = !q_full;
            DRAIN: begin
                req      = 1'b1;
                req_addr = drain_addr_q;
            end
            default: req = 1'b0;
        endcase
    end

    assign push = (state_q == FETCH) && req && bus.imem_ready && !bus.redirect_valid;
    assign pop  = bus.instr_valid && bus.instr_ready;

    // pc always points at the next address to fetch; drain_addr keeps the abandoned one on the bus.
    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        if (bus.redirect_valid) begin
            pc_d = word_align(bus.redirect_target);
            if (state_q != DRAIN) drain_addr_d = pc_q;
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign q_in.instr = bus.imem_rdata;
    assign q_in.pc    = pc_q;

    instr_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (q_in),
        .pop_i      (pop),
        .flush_i    (bus.redirect_valid),
        .head_dat_o (q_head),
        .count_o    (q_count),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    assign bus.imem_req    = rst && req;
    assign bus.imem_addr   = req_addr;
    assign bus.instr_valid = rst && !q_empty;
    assign bus.instr       = rst ? q_head.instr : '0;
    assign bus.instr_pc    = rst ? q_head.pc    : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table for the corner cases, then randomized traffic vs a queue model.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        r, rdy, ir, rv;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic        e_zero;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] m_pc, m_daddr;
    bit          m_drain;
    logic [31:0] m_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        return {h[31:7], (a[2] ? OP_BRANCH : OP_IMM)};
    endfunction

    function automatic vec_t v(input logic r, rdy, ir, rv, input logic [31:0] tgt,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_val, input logic [31:0] e_pc, input logic e_zero);
        vec_t x;
        x.r = r; x.rdy = rdy; x.ir = ir; x.rv = rv; x.tgt = tgt;
        x.e_req = e_req; x.e_addr = e_addr; x.e_val = e_val; x.e_pc = e_pc; x.e_zero = e_zero;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, rdy, ir, rv, input logic [31:0] tgt);
        rst                 = r;
        bus.imem_ready      = rdy;
        bus.instr_ready     = ir;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.imem_rdata      = mem_word(bus.imem_addr);
        #1;
    endtask

    initial begin
        // r rdy ir rv tgt | req addr | valid pc | zero
        vecs.push_back(v(0,0,0,0,0,            0,0,               0,0,               1));
        vecs.push_back(v(0,0,0,0,0,            0,0,               0,0,               1));
        vecs.push_back(v(1,1,1,0,0,            1,RPC,             0,0,               1));
        vecs.push_back(v(1,1,1,0,0,            1,RPC+32'h4,       1,RPC,             0));
        vecs.push_back(v(1,1,1,0,0,            1,RPC+32'h8,       1,RPC+32'h4,       0));
        vecs.push_back(v(1,1,0,0,0,            1,RPC+32'hC,       1,RPC+32'h8,       0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v(1,1,0,0,0,        0,0,               1,RPC+32'h8,       0));
        vecs.push_back(v(1,1,1,0,0,            0,0,               1,RPC+32'h8,       0));
        vecs.push_back(v(1,0,1,0,0,            1,RPC+32'h10,      1,RPC+32'hC,       0));
        vecs.push_back(v(1,0,1,0,0,            1,RPC+32'h10,      0,0,               0));
        vecs.push_back(v(1,0,1,0,0,            1,RPC+32'h10,      0,0,               0));
        vecs.push_back(v(1,1,1,0,0,            1,RPC+32'h10,      0,0,               0));
        vecs.push_back(v(1,0,0,0,0,            1,RPC+32'h14,      1,RPC+32'h10,      0));
        vecs.push_back(v(1,0,0,1,32'h103,      1,RPC+32'h14,      1,RPC+32'h10,      0));
        vecs.push_back(v(1,0,0,0,0,            1,RPC+32'h14,      0,0,               0));
        vecs.push_back(v(1,1,0,0,0,            1,RPC+32'h14,      0,0,               0));
        vecs.push_back(v(1,1,1,0,0,            1,32'h100,         0,0,               0));
        vecs.push_back(v(1,1,1,0,0,            1,32'h104,         1,32'h100,         0));
        vecs.push_back(v(1,1,1,1,32'h2000,     1,32'h108,         1,32'h104,         0));
        vecs.push_back(v(1,0,1,0,0,            1,32'h2000,        0,0,               0));
        vecs.push_back(v(1,1,1,0,0,            1,32'h2000,        0,0,               0));
        vecs.push_back(v(1,0,0,0,0,            1,32'h2004,        1,32'h2000,        0));
        vecs.push_back(v(1,1,0,0,0,            1,32'h2004,        1,32'h2000,        0));
        vecs.push_back(v(0,1,1,0,0,            0,0,               0,0,               1));
        vecs.push_back(v(1,0,0,0,0,            1,RPC,             0,0,               1));
        vecs.push_back(v(1,1,1,1,32'hFFFF_FFFE,1,RPC,             0,0,               1));
        vecs.push_back(v(1,1,1,0,0,            1,32'hFFFF_FFFC,   0,0,               0));
        vecs.push_back(v(1,1,1,0,0,            1,32'h0,           1,32'hFFFF_FFFC,   0));
        vecs.push_back(v(1,0,1,0,0,            1,32'h4,           1,32'h0,           0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].rdy, vecs[i].ir, vecs[i].rv, vecs[i].tgt);
            chk($sformatf("vec%0d imem_req", i), 32'(bus.imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req)
                chk($sformatf("vec%0d imem_addr", i), bus.imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_val));
            if (vecs[i].e_val) begin
                chk($sformatf("vec%0d instr_pc", i), bus.instr_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d instr", i), bus.instr, mem_word(vecs[i].e_pc));
            end
            if (vecs[i].e_zero) begin
                chk($sformatf("vec%0d instr zero", i), bus.instr, 32'h0);
                chk($sformatf("vec%0d instr_pc zero", i), bus.instr_pc, 32'h0);
            end
            @(posedge clk);
            #1;
        end

        m_pc    = RPC;
        m_daddr = RPC;
        m_drain = 0;
        for (int c = 0; c < 800; c++) begin
            logic        r, rdy, ir, rv, e_req;
            logic [31:0] tgt, e_addr;
            r   = (c == 0) ? 1'b0 : ($urandom_range(99) >= 2);
            rdy = ($urandom_range(99) < 60);
            ir  = ($urandom_range(99) < 65);
            rv  = ($urandom_range(99) < 7);
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            e_req  = m_drain || (m_q.size() < 2);
            e_addr = m_drain ? m_daddr : m_pc;
            drive(r, rdy, ir, rv, tgt);
            if (!r) begin
                chk("rnd reset imem_req", 32'(bus.imem_req), 32'h0);
                chk("rnd reset instr_valid", 32'(bus.instr_valid), 32'h0);
                chk("rnd reset instr", bus.instr, 32'h0);
                chk("rnd reset instr_pc", bus.instr_pc, 32'h0);
            end else begin
                chk($sformatf("rnd%0d imem_req", c), 32'(bus.imem_req), 32'(e_req));
                if (e_req)
                    chk($sformatf("rnd%0d imem_addr", c), bus.imem_addr, e_addr);
                chk($sformatf("rnd%0d instr_valid", c), 32'(bus.instr_valid), 32'(m_q.size() != 0));
                if (m_q.size() != 0) begin
                    chk($sformatf("rnd%0d instr_pc", c), bus.instr_pc, m_q[0]);
                    chk($sformatf("rnd%0d instr", c), bus.instr, mem_word(m_q[0]));
                end
            end
            @(posedge clk);
            #1;
            if (!r) begin
                m_q.delete();
                m_pc    = RPC;
                m_drain = 0;
            end else begin
                if (m_q.size() != 0 && ir) void'(m_q.pop_front());
                if (rv) begin
                    m_q.delete();
                    if (e_req && !rdy) begin
                        if (!m_drain) m_daddr = m_pc;
                        m_drain = 1;
                    end else begin
                        m_drain = 0;
                    end
                    m_pc = {tgt[31:2], 2'b00};
                end else if (m_drain) begin
                    if (rdy) m_drain = 0;
                end else if (e_req && rdy) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
